// File: rtl/uart_frame_reader_if.sv
// uart_frame_reader_if: RX FIFO read side plus frame valid/ready and status signals; master = reader, slave = FIFO/consumer side
interface uart_frame_reader_if #(parameter int PAYLOAD_LEN = 2);
  logic fifo_empty;
  logic [7:0] fifo_q;
  logic fifo_rdreq;
  logic frame_valid;
  logic frame_ready;
  logic [7:0] frame_cmd;
  logic [8*PAYLOAD_LEN-1:0] frame_payload;
  logic err_checksum;
  logic err_timeout;
  logic [7:0] drop_count;
  modport master (
    input fifo_empty, fifo_q, frame_ready,
    output fifo_rdreq, frame_valid, frame_cmd, frame_payload, err_checksum, err_timeout, drop_count
  );
  modport slave (
    output fifo_empty, fifo_q, frame_ready,
    input fifo_rdreq, frame_valid, frame_cmd, frame_payload, err_checksum, err_timeout, drop_count
  );
endinterface

// File: rtl/uart_frame_reader.sv
// uart_frame_reader: drains RX FIFO into HEADER/CMD/payload/CHK frames; ports clk, rst (async high), bus (master: FIFO read, frame valid/ready, error pulses, drop count)
module uart_frame_reader #(
  parameter logic [7:0] HEADER = 8'hAA,
  parameter int PAYLOAD_LEN = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic clk,
  input logic rst,
  uart_frame_reader_if.master bus
);
  localparam int PW = 8 * PAYLOAD_LEN;
  localparam int IW = $clog2(PAYLOAD_LEN + 3);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, FETCH, CAPTURE, OUT} state_t;
  state_t state, next;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;
  logic [7:0] acc;
  logic last, chk_ok;
  assign last = idx == IW'(PAYLOAD_LEN + 2);
  assign chk_ok = bus.fifo_q == acc;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state == IDLE    ? (bus.fifo_empty ? IDLE : FETCH) :
           state == FETCH   ? CAPTURE :
           state == CAPTURE ? ((last && chk_ok) ? OUT : IDLE) :
                              (bus.frame_ready ? IDLE : OUT);
  end
  always_comb begin
    bus.fifo_rdreq = state == FETCH;
    bus.frame_valid = state == OUT;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
      cnt <= '0;
      acc <= '0;
      bus.frame_cmd <= '0;
      bus.frame_payload <= '0;
      bus.err_checksum <= 1'b0;
      bus.err_timeout <= 1'b0;
      bus.drop_count <= '0;
    end else begin
      bus.err_checksum <= 1'b0;
      bus.err_timeout <= 1'b0;
      // inter-byte timeout only runs while a frame is partially assembled
      if (state == IDLE && bus.fifo_empty && idx != '0) begin
        if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          bus.err_timeout <= 1'b1;
          idx <= '0;
          cnt <= '0;
        end else cnt <= cnt + 1'b1;
      end
      if (state == CAPTURE) begin
        cnt <= '0;
        if (idx == '0) begin
          if (bus.fifo_q == HEADER) begin
            idx <= IW'(1);
            acc <= '0;
          end else if (bus.drop_count != 8'hFF) bus.drop_count <= bus.drop_count + 8'd1;
        end else if (idx == IW'(1)) begin
          bus.frame_cmd <= bus.fifo_q;
          acc <= acc ^ bus.fifo_q;
          idx <= IW'(2);
        end else if (!last) begin
          bus.frame_payload <= (bus.frame_payload << 8) | PW'(bus.fifo_q);
          acc <= acc ^ bus.fifo_q;
          idx <= idx + 1'b1;
        end else begin
          idx <= '0;
          bus.err_checksum <= !chk_ok;
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_frame_reader.sv
// tb_uart_frame_reader: directed-vector bench with a behavioral RX FIFO and pulse monitors
module tb_uart_frame_reader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_pass = 0;
  logic [7:0] mem [0:1023];
  int wr = 0;
  int rd = 0;
  int rd_pulses = 0;
  int n_cks = 0;
  int n_to = 0;
  int consec = 0;
  int overlap = 0;
  int empty_reads = 0;
  logic prev_rdreq = 1'b0;
  int r;
  int ne0;
  int nt0;
  uart_frame_reader_if #(.PAYLOAD_LEN(2)) bus ();
  uart_frame_reader #(.HEADER(8'hAA), .PAYLOAD_LEN(2), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );
  always #5 clk = ~clk;
  assign bus.fifo_empty = (rd == wr);
  always @(posedge clk) begin
    prev_rdreq <= bus.fifo_rdreq;
    if (bus.fifo_rdreq) begin
      rd_pulses <= rd_pulses + 1;
      if (rd == wr) empty_reads <= empty_reads + 1;
      else begin
        bus.fifo_q <= mem[rd];
        rd <= rd + 1;
      end
    end
    if (bus.fifo_rdreq && prev_rdreq) consec <= consec + 1;
    if (bus.err_checksum) n_cks <= n_cks + 1;
    if (bus.err_timeout) n_to <= n_to + 1;
    if (bus.frame_valid && (bus.err_checksum || bus.err_timeout)) overlap <= overlap + 1;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  task automatic push(input logic [7:0] b);
    mem[wr] = b;
    wr++;
  endtask
  task automatic push5(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d, input logic [7:0] e);
    push(a); push(b); push(c); push(d); push(e);
  endtask
  task automatic wait_valid();
    for (int i = 0; i < 300 && !bus.frame_valid; i++) @(negedge clk);
    check("valid_seen", 32'(bus.frame_valid), 32'd1);
  endtask
  task automatic get_frame(input logic [7:0] cmd, input logic [15:0] pl);
    wait_valid();
    check("cmd", 32'(bus.frame_cmd), 32'(cmd));
    check("payload", 32'(bus.frame_payload), 32'(pl));
    bus.frame_ready = 1'b1;
    @(posedge clk);
    #1;
    check("valid_drop", 32'(bus.frame_valid), 32'd0);
    bus.frame_ready = 1'b0;
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_rdreq"}, 32'(bus.fifo_rdreq), 32'd0);
    check({tag, "_valid"}, 32'(bus.frame_valid), 32'd0);
    check({tag, "_cmd"}, 32'(bus.frame_cmd), 32'd0);
    check({tag, "_payload"}, 32'(bus.frame_payload), 32'd0);
    check({tag, "_errs"}, 32'({bus.err_checksum, bus.err_timeout}), 32'd0);
    check({tag, "_drop"}, 32'(bus.drop_count), 32'd0);
  endtask
  initial begin
    bus.frame_ready = 1'b0;
    bus.fifo_q = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    r = rd_pulses;
    ne0 = n_cks;
    nt0 = n_to;
    push5(8'hAA, 8'h10, 8'h12, 8'h34, 8'h36);
    get_frame(8'h10, 16'h1234);
    check("valid_rdreqs", 32'(rd_pulses - r), 32'd5);
    check("valid_noerr", 32'(n_cks - ne0 + n_to - nt0), 32'd0);
    ne0 = n_cks;
    push5(8'hAA, 8'h10, 8'h12, 8'h34, 8'h00);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.frame_valid) check("bad_no_valid", 32'd1, 32'd0);
    end
    check("bad_pulse", 32'(n_cks - ne0), 32'd1);
    push5(8'hAA, 8'h01, 8'h00, 8'h00, 8'h01);
    get_frame(8'h01, 16'h0000);
    check("hunt_drop0", 32'(bus.drop_count), 32'd0);
    push(8'h55);
    push(8'h66);
    push5(8'hAA, 8'h10, 8'h12, 8'h34, 8'h36);
    get_frame(8'h10, 16'h1234);
    check("hunt_drop2", 32'(bus.drop_count), 32'd2);
    for (int i = 0; i < 300; i++) push(8'h55);
    repeat (950) @(negedge clk);
    check("hunt_sat", 32'(bus.drop_count), 32'd255);
    r = rd_pulses;
    nt0 = n_to;
    push(8'hAA);
    push(8'h10);
    for (int i = 0; i < 100 && rd_pulses < r + 2; i++) @(negedge clk);
    check("to_fetch", 32'(rd_pulses - r), 32'd2);
    repeat (16) @(posedge clk);
    #1;
    check("to_early", 32'(bus.err_timeout), 32'd0);
    @(posedge clk);
    #1;
    check("to_pulse", 32'(bus.err_timeout), 32'd1);
    @(posedge clk);
    #1;
    check("to_end", 32'(bus.err_timeout), 32'd0);
    check("to_count", 32'(n_to - nt0), 32'd1);
    push5(8'hAA, 8'h20, 8'h00, 8'h01, 8'h21);
    get_frame(8'h20, 16'h0001);
    push5(8'hAA, 8'h40, 8'h01, 8'h02, 8'h43);
    push5(8'hAA, 8'h50, 8'h05, 8'h06, 8'h53);
    wait_valid();
    r = rd_pulses;
    repeat (10) @(negedge clk);
    check("bp_valid", 32'(bus.frame_valid), 32'd1);
    check("bp_noread", 32'(rd_pulses - r), 32'd0);
    get_frame(8'h40, 16'h0102);
    get_frame(8'h50, 16'h0506);
    ne0 = n_cks;
    nt0 = n_to;
    r = rd_pulses;
    push5(8'hAA, 8'h10, 8'h12, 8'h34, 8'h36);
    for (int i = 0; i < 100 && rd_pulses < r + 3; i++) @(negedge clk);
    check("rst_fetch", 32'(rd_pulses - r), 32'd3);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    push5(8'hAA, 8'h30, 8'h00, 8'h00, 8'h30);
    get_frame(8'h30, 16'h0000);
    check("rst_drop", 32'(bus.drop_count), 32'd2);
    check("rst_noerr", 32'(n_cks - ne0 + n_to - nt0), 32'd0);
    check("no_consec_rdreq", 32'(consec), 32'd0);
    check("no_err_with_valid", 32'(overlap), 32'd0);
    check("no_empty_read", 32'(empty_reads), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
